// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

  localparam int XLEN = 32;
  localparam int HALF = 16;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Sign of operand 1 is honoured by MULH and MULHSU.
  function automatic logic x1_signed(input funct_t f);
    return (f == MULH) || (f == MULHSU);
  endfunction

  // Sign of operand 2 is honoured by MULH only.
  function automatic logic x2_signed(input funct_t f);
    return (f == MULH);
  endfunction

endpackage

// File: rtl/umul16x16.sv
// Combinational unsigned 16x16 -> 32 multiplier, shared by all four steps.
module umul16x16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  // Full-width product; operands are zero-extended so nothing is truncated.
  assign o_p = {16'd0, i_a} * {16'd0, i_b};

endmodule

// File: rtl/mul_seq.sv
// Iterative 32x32 multiplier: four 16x16 partial products, one per cycle,
// returning the low word (MUL, with unsigned overflow) or the high word.
module mul_seq #(
  parameter int XLEN = mul_pkg::XLEN  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] x1,
  input  logic [XLEN-1:0] x2,
  input  logic [1:0]      funct,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] y,
  output logic            ovf,
  output logic            out_valid,
  input  logic            out_ready
);

  import mul_pkg::*;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_k;
  logic [63:0]   r_acc;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_neg;
  funct_t        r_funct;
  logic [31:0]   r_y;
  logic          r_ovf;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_out_fire;
  logic          w_last;
  funct_t        w_funct_in;
  logic          w_s1;
  logic          w_s2;
  logic [15:0]   w_a_half;
  logic [15:0]   w_b_half;
  logic [31:0]   w_pp;
  logic [63:0]   w_term;
  logic [63:0]   w_sum;
  logic [63:0]   w_prod;

  assign w_funct_in = funct_t'(funct);
  assign w_s1       = x1_signed(w_funct_in) & x1[XLEN-1];
  assign w_s2       = x2_signed(w_funct_in) & x2[XLEN-1];

  // Ready is gated by rst so nothing is accepted while the block is held in reset.
  assign in_ready   = (r_state == IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_last     = (r_state == CALC) && (r_k == 2'd3);

  // Step counter picks which operand halves feed the shared multiplier:
  // k0 lo*lo, k1 lo*hi, k2 hi*lo, k3 hi*hi.
  assign w_a_half = r_k[1] ? r_a[31:HALF] : r_a[HALF-1:0];
  assign w_b_half = r_k[0] ? r_b[31:HALF] : r_b[HALF-1:0];

  umul16x16 u_umul (
    .i_a (w_a_half),
    .i_b (w_b_half),
    .o_p (w_pp)
  );

  // Align the partial product to its weight in the 64-bit result.
  always_comb begin
    w_term = 64'd0;
    case (r_k)
      2'd0:    w_term = {32'd0, w_pp};
      2'd1,
      2'd2:    w_term = {16'd0, w_pp, 16'd0};
      default: w_term = {w_pp, 32'd0};
    endcase
  end

  // Running sum wraps modulo 2^64; the magnitude product always fits in 64 bits.
  assign w_sum  = r_acc + w_term;
  assign w_prod = r_neg ? (64'd0 - w_sum) : w_sum;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_next = CALC;
      CALC:    if (w_last)     w_state_next = DONE;
      DONE:    if (w_out_fire) w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Operand capture, step counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= 2'd0;
      r_acc   <= 64'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_neg   <= 1'b0;
      r_funct <= MUL;
    end else if (w_accept) begin
      // Operands become unsigned magnitudes; 0x8000_0000 negates to 2^31,
      // which is still correct when read as unsigned.
      r_k     <= 2'd0;
      r_acc   <= 64'd0;
      r_a     <= w_s1 ? (32'd0 - x1) : x1;
      r_b     <= w_s2 ? (32'd0 - x2) : x2;
      r_neg   <= w_s1 ^ w_s2;
      r_funct <= w_funct_in;
    end else if (r_state == CALC) begin
      r_k   <= r_k + 2'd1;
      r_acc <= w_last ? 64'd0 : w_sum;
    end
  end

  // Result registers: loaded on the final step, held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= 32'd0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_y         <= (r_funct == MUL) ? w_prod[31:0] : w_prod[63:32];
      r_ovf       <= (r_funct == MUL) && (w_sum[63:32] != 32'd0);
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = r_y;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with hand-computed expected results.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [1:0]  funct;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .funct     (funct),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present one operation, then wait for out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                       input string tag, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, " ready_seen"}, 64'(in_ready), 64'd1);
    x1 = a; x2 = b; funct = f; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    x1 = 32'hDEAD_BEEF; x2 = 32'hCAFE_F00D; funct = 2'b11;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                        input logic [31:0] ey, input logic eovf, input string tag);
    int lat;
    issue(a, b, f, tag, lat);
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " y"}, 64'(y), 64'(ey));
    chk({tag, " ovf"}, 64'(ovf), 64'(eovf));
  endtask

  initial begin
    int lat;
    logic [31:0] held_y;
    rst = 1'b1; x1 = '0; x2 = '0; funct = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset y", 64'(y), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);

    // Basic MUL and overflow cases, zero-wait consumer.
    run_op(32'd3, 32'd5, 2'b00, 32'h0000_000F, 1'b0, "mul 3x5");
    run_op(32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 1'b1, "mul 2^16x2^16");
    run_op(32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFE, 1'b1, "mul ffffffffx2");
    run_op(32'hFFFF_FFFD, 32'd5, 2'b00, 32'hFFFF_FFF1, 1'b1, "mul -3x5");
    // High-word variants on -1 x 2.
    run_op(32'hFFFF_FFFF, 32'd2, 2'b01, 32'hFFFF_FFFF, 1'b0, "mulh -1x2");
    run_op(32'hFFFF_FFFF, 32'd2, 2'b10, 32'hFFFF_FFFF, 1'b0, "mulhsu -1x2");
    run_op(32'hFFFF_FFFF, 32'd2, 2'b11, 32'h0000_0001, 1'b0, "mulhu ffffffffx2");
    // Most-negative operand cases.
    run_op(32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 1'b0, "mulh min x min");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 1'b0, "mulhsu min x umax");

    // Backpressure: hold the result for three cycles with a competing request.
    step();
    out_ready = 1'b0;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, "bp", lat);
    chk("bp y", 64'(y), 64'h0000_0000_FFFF_FFFE);
    held_y = 32'hFFFF_FFFE;
    x1 = 32'd1; x2 = 32'd1; funct = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold%0d y", i), 64'(y), 64'(held_y));
      chk($sformatf("bp hold%0d ovf", i), 64'(ovf), 64'd0);
      chk($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp no ghost%0d", i), 64'(out_valid), 64'd0);
    end

    // Reset pulse while the step counter is at 2.
    x1 = 32'h1234_5678; x2 = 32'h9ABC_DEF0; funct = 2'b00; in_valid = 1'b1;
    step();                  // accept edge
    in_valid = 1'b0;
    step(); step();          // now at k=2
    rst = 1'b1;
    #1;
    chk("rst held in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst y", 64'(y), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (out_valid) seen++;
      end
      chk("rst no stale result", 64'(seen), 64'd0);
    end
    run_op(32'd7, 32'd9, 2'b00, 32'h0000_003F, 1'b0, "post-rst mul 7x9");

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative 32×32 integer multiplier for the execute stage. It accepts operands from issue/decode over a valid/ready handshake and builds the full 64-bit product from four 16×16 partial products, one per cycle. It returns either the low word (MUL, with the team's unsigned-overflow flag) or the high word (MULH/MULHSU/MULHU) to writeback over a second valid/ready handshake. It trades latency for area against the single-cycle combinational multiplier.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x1  in  32  multiplicand; sampled on input handshake.
- x2  in  32  multiplier; sampled on input handshake.
- funct  in  2  00 MUL, 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u); sampled on input handshake.
- in_valid  in  1  operands valid.
- in_ready  out  1  high only in IDLE and only while rst is low.
- y  out  32  result; valid while out_valid.
- ovf  out  1  overflow flag; valid while out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, CALC, DONE. CALC has a 2-bit step counter k (0..3).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch funct.
  - s1 = x1[31] when funct is MULH or MULHSU, else 0. s2 = x2[31] when funct is MULH, else 0.
  - a = s1 ? -x1 : x1 and b = s2 ? -x2 : x2, both as 32-bit unsigned magnitudes. neg = s1^s2.
  - Clear 64-bit acc; go to CALC with k=0.
- CALC, one partial product per cycle:
  - k0: acc += a[15:0]·b[15:0].
  - k1: acc += (a[15:0]·b[31:16])<<16.
  - k2: acc += (a[31:16]·b[15:0])<<16.
  - k3: acc += (a[31:16]·b[31:16])<<32.
  - acc sum is modulo 2^64; no carry is lost.
- At k3, form the final value combinationally from acc plus the k3 term: p = neg ? -sum : sum (64-bit two's complement).
  - Register y = (funct==MUL) ? p[31:0] : p[63:32].
  - Register ovf = (funct==MUL) && (sum[63:32]!=0); always 0 for the high-word functs.
  - Set out_valid=1; go to DONE.
- DONE:
  - y, ovf and out_valid are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_valid&&out_ready: clear out_valid and go to IDLE.
- MUL takes no sign handling (s1=s2=0), so p[31:0] equals the signed/unsigned low word and ovf is the unsigned >32-bit overflow used elsewhere in the codebase.
- Operands with value 0x8000_0000 negate to magnitude 2^31; this is handled correctly as unsigned.

## Timing
- Reset values (rst high at an edge):
  - state=IDLE, k=0, acc=0.
  - y=0, ovf=0, out_valid=0.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
- Latency: input handshake at edge t0, then out_valid is high after edge t4 (4 cycles).
- Throughput: at most one operation per 5 cycles plus the DONE dwell. No overlap; in_ready stays low from acceptance until the output handshake edge.
- Zero-wait consumer: out_ready high at t4 gives the output handshake in cycle t4→t5, IDLE after t5, and the next accept possible at edge t6.
- Reset mid-operation (CALC or DONE): the operation is dropped and its result is never presented.
- Inputs x1, x2, funct are don't-care outside the accepting cycle.

## Structure
- Shared package mul_pkg holds:
  - the funct_t enum (MUL, MULH, MULHSU, MULHU = 2'b00..2'b11);
  - the state_t enum (IDLE, CALC, DONE);
  - the XLEN and HALF (16) constants.
- One sub-module, umul16x16: combinational unsigned 16×16→32. It is instantiated once; the step counter muxes the operand halves into it.
- The accumulator, negation and result select live in mul_seq.

## Test plan
- MUL 3×5 → y=0x0000_000F, ovf=0. out_valid is high exactly 4 cycles after accept, with out_ready tied high.
- MUL 0x0001_0000×0x0001_0000 → y=0x0000_0000, ovf=1. MUL 0xFFFF_FFFF×2 → y=0xFFFF_FFFE, ovf=1.
- x1=0xFFFF_FFFF, x2=2, run with each funct:
  - MULH → 0xFFFF_FFFF, ovf=0.
  - MULHSU → 0xFFFF_FFFF, ovf=0.
  - MULHU → 0x0000_0001, ovf=0.
- MULH 0x8000_0000×0x8000_0000 → 0x4000_0000. MULHSU 0x8000_0000×0xFFFF_FFFF → 0x8000_0000.
- Backpressure: out_ready low for 3 cycles after out_valid.
  - y, ovf and out_valid stay stable; in_ready stays 0.
  - A concurrent in_valid is ignored.
  - Raising out_ready gives IDLE and in_ready=1 the next cycle.
- rst pulsed for one cycle at CALC k=2:
  - out_valid=0, y=0, in_ready=1 after release.
  - No stale result appears.
  - A subsequent MUL 7×9 yields 0x3F.
